// File: rtl/game_pkg.sv
// game_pkg: shared types and defaults for the coin acceptor, credit manager and game FSM.
package game_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, PLAYING} credit_state_t;
  localparam int MAX_GAMES_DEFAULT = 7;
  localparam int CW_DEFAULT = 4;
endpackage

// File: rtl/game_credit_manager_if.sv
// game_credit_manager_if: acceptor/button/game-FSM handshake bundle for the credit manager.
interface game_credit_manager_if #(parameter int CW = game_pkg::CW_DEFAULT);
  logic Drop;
  logic StartGame;
  logic GameOver;
  logic [CW-1:0] NumGames;
  logic GameStart;
  logic GameActive;
  logic CoinRejected;
  modport master(output Drop, StartGame, GameOver, input NumGames, GameStart, GameActive, CoinRejected);
  modport slave(input Drop, StartGame, GameOver, output NumGames, GameStart, GameActive, CoinRejected);
endinterface

// File: rtl/game_credit_manager_rise_detect.sv
// rise_detect: rising-edge detector whose history resets high so a level held through reset never fires.
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q <= 1'b1;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/game_credit_manager.sv
// game_credit_manager: banks coin-drop credits and spends one per debounced StartGame edge.
module game_credit_manager
  import game_pkg::*;
#(
  parameter int MAX_GAMES = MAX_GAMES_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input logic clock,
  input logic reset_n,
  game_credit_manager_if.slave bus
);
  credit_state_t state, state_next;
  logic [CW-1:0] num_games, num_next;
  logic game_start, coin_rejected;
  logic start_edge, inc, dec, full, reject;
  rise_detect u_rise (.clock(clock), .reset_n(reset_n), .d(bus.StartGame), .rise(start_edge));
  always_comb begin
    inc = bus.Drop;
    dec = (state == IDLE) & start_edge & (num_games != '0);
    full = num_games == CW'(MAX_GAMES);
    reject = inc & ~dec & full;
    num_next = (inc & dec) ? num_games :
               inc ? (full ? num_games : num_games + 1'b1) :
               dec ? num_games - 1'b1 : num_games;
    // GameOver is only honoured from PLAYING; the 2'b11 encoding falls back to IDLE
    state_next = (state == IDLE) ? (dec ? LAUNCH : IDLE) :
                 (state == LAUNCH) ? PLAYING :
                 (state == PLAYING) ? (bus.GameOver ? IDLE : PLAYING) : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      num_games <= '0;
      game_start <= 1'b0;
      coin_rejected <= 1'b0;
    end else begin
      state <= state_next;
      num_games <= num_next;
      game_start <= dec;
      coin_rejected <= reject;
    end
  assign bus.NumGames = num_games;
  assign bus.GameStart = game_start;
  assign bus.GameActive = (state == LAUNCH) | (state == PLAYING);
  assign bus.CoinRejected = coin_rejected;
endmodule
